// File: rtl/layer_norm_pkg.sv
// Shared definitions for the layer-norm request scheduler.
// Holds default datapath width and row length, the scheduler state type,
// and a clog2 helper that never returns zero (for 1-entry index fields).
package layer_norm_pkg;

  localparam int DEF_D_W_ACC = 32;
  localparam int DEF_N       = 768;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    GAP    = 2'd2
  } state_t;

  function automatic int safe_clog2(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/layer_norm_sched_if.sv
// Bus bundle between requesters, the scheduler and the layer-norm datapath.
// Ports (scheduler view = slave):
//   req_valid/req_ready/req_qin/req_bias/req_shift : per-requester element lanes
//   ln_enable/ln_in_valid/ln_qin/ln_bias/ln_shift  : operands to the datapath
//   ln_out_valid/ln_qout                           : result stream from the datapath
//   rsp_valid/rsp_id/rsp_data/rsp_last             : routed results, no backpressure
//   busy/err_underrun/err_orphan                   : status and sticky errors
// The master modport is the environment (requesters + datapath) side.
interface layer_norm_sched_if
  import layer_norm_pkg::*;
#(
  parameter int D_W_ACC = DEF_D_W_ACC,
  parameter int NUM_REQ = 2
) ();

  localparam int SH_W = $clog2(D_W_ACC);
  localparam int ID_W = safe_clog2(NUM_REQ);

  logic [NUM_REQ-1:0]              req_valid;
  logic [NUM_REQ-1:0]              req_ready;
  logic [NUM_REQ-1:0][D_W_ACC-1:0] req_qin;
  logic [NUM_REQ-1:0][D_W_ACC-1:0] req_bias;
  logic [NUM_REQ-1:0][SH_W-1:0]    req_shift;

  logic                            ln_enable;
  logic                            ln_in_valid;
  logic signed [D_W_ACC-1:0]       ln_qin;
  logic signed [D_W_ACC-1:0]       ln_bias;
  logic [SH_W-1:0]                 ln_shift;
  logic                            ln_out_valid;
  logic signed [D_W_ACC-1:0]       ln_qout;

  logic                            rsp_valid;
  logic [ID_W-1:0]                 rsp_id;
  logic signed [D_W_ACC-1:0]       rsp_data;
  logic                            rsp_last;

  logic                            busy;
  logic                            err_underrun;
  logic                            err_orphan;

  modport slave (
    input  req_valid, req_qin, req_bias, req_shift, ln_out_valid, ln_qout,
    output req_ready, ln_enable, ln_in_valid, ln_qin, ln_bias, ln_shift,
           rsp_valid, rsp_id, rsp_data, rsp_last, busy, err_underrun, err_orphan
  );

  modport master (
    output req_valid, req_qin, req_bias, req_shift, ln_out_valid, ln_qout,
    input  req_ready, ln_enable, ln_in_valid, ln_qin, ln_bias, ln_shift,
           rsp_valid, rsp_id, rsp_data, rsp_last, busy, err_underrun, err_orphan
  );

endinterface

// File: rtl/sync_fifo.sv
// Small synchronous FIFO used as the in-flight row tag queue.
// Ports:
//   clk, rst       : clock, synchronous active-high reset (empties the queue)
//   i_push, i_din  : write strobe and data (ignored when full)
//   i_pop          : read strobe (ignored when empty)
//   o_dout         : head entry (valid when !o_empty)
//   o_full, o_empty: occupancy flags
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo
  import layer_norm_pkg::*;
#(
  parameter int W     = 1,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_din,
  input  logic         i_pop,
  output logic [W-1:0] o_dout,
  output logic         o_full,
  output logic         o_empty
);

  localparam int AW = safe_clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_dout    = r_mem[r_rd];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + 1'b1;
      if (w_do_pop)  r_rd <= r_rd + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr] <= i_din;
  end

endmodule

// File: rtl/layer_norm_sched.sv
// Round-robin scheduler that shares one layer-norm datapath among NUM_REQ
// requesters. A granted requester streams exactly N elements (one per cycle),
// followed by ROW_GAP idle cycles. Each grant pushes the requester id into a
// tag queue; the datapath result stream is routed back by that queue, one
// row of N beats per tag.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset (clears state, queue, outputs, errors)
//   bus  : layer_norm_sched_if.slave bundle (requesters, datapath, responses)
module layer_norm_sched
  import layer_norm_pkg::*;
#(
  parameter int D_W_ACC = DEF_D_W_ACC,
  parameter int N       = DEF_N,
  parameter int NUM_REQ = 2,
  parameter int MAX_OUT = 4,
  parameter int ROW_GAP = 64
) (
  input  logic               clk,
  input  logic               rst,
  layer_norm_sched_if.slave  bus
);

  localparam int SH_W  = $clog2(D_W_ACC);
  localparam int ID_W  = safe_clog2(NUM_REQ);
  localparam int CNT_W = safe_clog2(((N > ROW_GAP) ? N : ROW_GAP) + 1);

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [CNT_W-1:0]          r_cnt;
  logic [CNT_W-1:0]          w_cnt_nxt;
  logic [ID_W-1:0]           r_grant;       // current / last granted requester
  logic [ID_W-1:0]           w_win;
  logic [ID_W-1:0]           w_idx;
  logic                      w_any;
  logic                      w_grant;
  logic                      w_lane_valid;
  logic [NUM_REQ-1:0]        w_ready;
  logic [SH_W-1:0]           r_shift;

  logic                      r_ln_en;
  logic                      r_ln_in_valid;
  logic signed [D_W_ACC-1:0] r_ln_qin;
  logic signed [D_W_ACC-1:0] r_ln_bias;
  logic                      r_err_u;

  logic [CNT_W-1:0]          r_ocnt;
  logic                      w_beat_ok;
  logic                      w_last_beat;
  logic                      r_rsp_valid;
  logic                      r_rsp_last;
  logic [ID_W-1:0]           r_rsp_id;
  logic signed [D_W_ACC-1:0] r_rsp_data;
  logic                      r_err_o;

  logic                      w_full;
  logic                      w_empty;
  logic [ID_W-1:0]           w_head;

  // Round-robin search starting one past the previous grant.
  always_comb begin
    w_any = 1'b0;
    w_win = r_grant;
    w_idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = ID_W'((int'(r_grant) + k) % NUM_REQ);
      if (!w_any && bus.req_valid[w_idx]) begin
        w_any = 1'b1;
        w_win = w_idx;
      end
    end
  end

  // Full check sees pre-pop occupancy, so a same-cycle pop never frees a slot early.
  assign w_grant      = (r_state == IDLE) && w_any && !w_full;
  assign w_lane_valid = bus.req_valid[r_grant];

  always_comb begin
    w_ready = '0;
    if (r_state == STREAM) w_ready[r_grant] = w_lane_valid;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      IDLE: begin
        if (w_grant) begin
          w_state_nxt = STREAM;
          w_cnt_nxt   = '0;
        end
      end
      STREAM: begin
        // Counts cycles, not accepted elements: a row always occupies N slots.
        if (r_cnt == CNT_W'(N - 1)) begin
          w_state_nxt = (ROW_GAP > 0) ? GAP : IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      GAP: begin
        if (r_cnt == CNT_W'(ROW_GAP - 1)) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_grant <= ID_W'(NUM_REQ - 1);
      r_shift <= '0;
    end else if (w_grant) begin
      r_grant <= w_win;
      r_shift <= bus.req_shift[w_win];
    end
  end

  // ---- input stage: accepted element -> datapath operands (1 cycle) ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ln_en       <= 1'b0;
      r_ln_in_valid <= 1'b0;
      r_ln_qin      <= '0;
      r_ln_bias     <= '0;
      r_err_u       <= 1'b0;
    end else begin
      r_ln_en       <= 1'b1;
      r_ln_in_valid <= (r_state == STREAM);
      if ((r_state == STREAM) && w_lane_valid) begin
        r_ln_qin  <= bus.req_qin[r_grant];
        r_ln_bias <= bus.req_bias[r_grant];
      end else begin
        r_ln_qin  <= '0;
        r_ln_bias <= '0;
      end
      if ((r_state == STREAM) && !w_lane_valid) r_err_u <= 1'b1;
    end
  end

  sync_fifo #(
    .W     (ID_W),
    .DEPTH (MAX_OUT)
  ) u_tag_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_grant),
    .i_din   (w_win),
    .i_pop   (w_last_beat),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_beat_ok   = bus.ln_out_valid && !w_empty;
  assign w_last_beat = w_beat_ok && (r_ocnt == CNT_W'(N - 1));

  // ---- output stage: datapath result -> routed response (1 cycle) ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ocnt      <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_last  <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_data  <= '0;
      r_err_o     <= 1'b0;
    end else begin
      r_rsp_valid <= w_beat_ok;
      r_rsp_last  <= w_last_beat;
      if (w_beat_ok) begin
        r_rsp_id   <= w_head;
        r_rsp_data <= bus.ln_qout;
        r_ocnt     <= w_last_beat ? '0 : r_ocnt + 1'b1;
      end else begin
        r_rsp_id   <= '0;
        r_rsp_data <= '0;
      end
      if (bus.ln_out_valid && w_empty) r_err_o <= 1'b1;
    end
  end

  assign bus.req_ready    = w_ready;
  assign bus.ln_enable    = r_ln_en;
  assign bus.ln_in_valid  = r_ln_in_valid;
  assign bus.ln_qin       = r_ln_qin;
  assign bus.ln_bias      = r_ln_bias;
  assign bus.ln_shift     = r_shift;
  assign bus.rsp_valid    = r_rsp_valid;
  assign bus.rsp_id       = r_rsp_id;
  assign bus.rsp_data     = r_rsp_data;
  assign bus.rsp_last     = r_rsp_last;
  assign bus.busy         = (r_state != IDLE) || !w_empty;
  assign bus.err_underrun = r_err_u;
  assign bus.err_orphan   = r_err_o;

endmodule

// File: tb/tb_layer_norm_sched.sv
// Directed testbench for layer_norm_sched with N=8, ROW_GAP=4, NUM_REQ=2,
// MAX_OUT=2. Inputs change 1 time unit after a rising edge; outputs are
// sampled 1 time unit after the edge (or 1 unit after an input change for
// purely combinational outputs).
module tb_layer_norm_sched;

  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  layer_norm_sched_if #(.D_W_ACC(DW), .NUM_REQ(2)) bus ();

  layer_norm_sched #(
    .D_W_ACC (DW),
    .N       (8),
    .NUM_REQ (2),
    .MAX_OUT (2),
    .ROW_GAP (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.req_valid    = '0;
    bus.req_qin      = '0;
    bus.req_bias     = '0;
    bus.req_shift    = '0;
    bus.ln_out_valid = 1'b0;
    bus.ln_qout      = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    rst = 1'b0;
  endtask

  // Feed one row of N=8 result beats; rsp must echo it one cycle later.
  task automatic return_row(input logic exp_id, input int base);
    for (int b = 0; b < 8; b++) begin
      bus.ln_out_valid = 1'b1;
      bus.ln_qout      = DW'(base + b);
      tick();
      n_tests++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== DW'(base + b) ||
          bus.rsp_id !== exp_id || bus.rsp_last !== (b == 7)) begin
        n_fail++;
        $display("FAIL rsp_beat[%0d]: got v=%b d=%0d id=%0d last=%b expected v=1 d=%0d id=%0d last=%b",
                 b, bus.rsp_valid, bus.rsp_data, bus.rsp_id, bus.rsp_last,
                 base + b, exp_id, (b == 7));
      end
    end
    bus.ln_out_valid = 1'b0;
    bus.ln_qout      = '0;
  endtask

  // Grant one row with both lanes holding constant values, then run it to IDLE.
  task automatic run_row(input int g);
    logic [1:0] exp_rdy;
    exp_rdy = (g == 0) ? 2'b01 : 2'b10;
    tick();
    n_tests++;
    if (bus.req_ready !== exp_rdy) begin
      n_fail++;
      $display("FAIL rr_grant: got ready=%b expected %b", bus.req_ready, exp_rdy);
    end
    n_tests++;
    if (bus.ln_shift !== 5'(g + 1)) begin
      n_fail++;
      $display("FAIL rr_shift: got %0d expected %0d", bus.ln_shift, g + 1);
    end
    for (int k = 1; k <= 8; k++) begin
      tick();
      n_tests++;
      if (bus.ln_qin !== DW'((g == 0) ? 10 : 20)) begin
        n_fail++;
        $display("FAIL rr_qin[%0d]: got %0d expected %0d", k, bus.ln_qin, (g == 0) ? 10 : 20);
      end
    end
    for (int k = 0; k < 4; k++) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    tick();
    n_tests++;
    if (bus.ln_enable !== 1'b0 || bus.ln_in_valid !== 1'b0 || bus.req_ready !== 2'b00 ||
        bus.busy !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.ln_shift !== 5'd0 ||
        bus.err_underrun !== 1'b0 || bus.err_orphan !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got en=%b iv=%b rdy=%b busy=%b rv=%b sh=%0d eu=%b eo=%b expected all 0",
               bus.ln_enable, bus.ln_in_valid, bus.req_ready, bus.busy, bus.rsp_valid,
               bus.ln_shift, bus.err_underrun, bus.err_orphan);
    end
    rst = 1'b0;
    tick();
    n_tests++;
    if (bus.ln_enable !== 1'b1 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: got en=%b busy=%b expected en=1 busy=0", bus.ln_enable, bus.busy);
    end
  endtask

  task automatic test_single_row();
    bus.req_valid    = 2'b01;
    bus.req_qin[0]   = DW'(1);
    bus.req_bias[0]  = DW'(101);
    bus.req_shift[0] = 5'd3;
    #1;
    n_tests++;
    if (bus.req_ready !== 2'b00) begin
      n_fail++;
      $display("FAIL single_idle_ready: got %b expected 00", bus.req_ready);
    end
    tick();
    n_tests++;
    if (bus.req_ready !== 2'b01 || bus.busy !== 1'b1 || bus.ln_in_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_grant: got rdy=%b busy=%b iv=%b expected rdy=01 busy=1 iv=0",
               bus.req_ready, bus.busy, bus.ln_in_valid);
    end
    bus.req_shift[0] = 5'd7;
    for (int k = 1; k <= 8; k++) begin
      tick();
      n_tests++;
      if (bus.ln_in_valid !== 1'b1 || bus.ln_qin !== DW'(k) || bus.ln_bias !== DW'(100 + k)) begin
        n_fail++;
        $display("FAIL single_elem[%0d]: got iv=%b qin=%0d bias=%0d expected iv=1 qin=%0d bias=%0d",
                 k, bus.ln_in_valid, bus.ln_qin, bus.ln_bias, k, 100 + k);
      end
      bus.req_qin[0]  = DW'(k + 1);
      bus.req_bias[0] = DW'(101 + k);
    end
    n_tests++;
    if (bus.ln_shift !== 5'd3) begin
      n_fail++;
      $display("FAIL single_shift_hold: got %0d expected 3", bus.ln_shift);
    end
    for (int g = 0; g < 4; g++) begin
      tick();
      n_tests++;
      if (bus.ln_in_valid !== 1'b0 || bus.req_ready !== 2'b00) begin
        n_fail++;
        $display("FAIL single_gap[%0d]: got iv=%b rdy=%b expected iv=0 rdy=00",
                 g, bus.ln_in_valid, bus.req_ready);
      end
    end
    bus.req_valid = 2'b00;
    n_tests++;
    if (bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_busy_inflight: got %b expected 1", bus.busy);
    end
    return_row(1'b0, 1000);
    tick();
    n_tests++;
    if (bus.busy !== 1'b0 || bus.rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_drained: got busy=%b rv=%b expected 0 0", bus.busy, bus.rsp_valid);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    bus.req_qin[0]   = DW'(10);
    bus.req_bias[0]  = DW'(11);
    bus.req_shift[0] = 5'd1;
    bus.req_qin[1]   = DW'(20);
    bus.req_bias[1]  = DW'(21);
    bus.req_shift[1] = 5'd2;
    bus.req_valid    = 2'b11;
    run_row(0);
    run_row(1);
    for (int c = 0; c < 3; c++) begin
      tick();
      n_tests++;
      if (bus.req_ready !== 2'b00 || bus.ln_in_valid !== 1'b0 || bus.busy !== 1'b1) begin
        n_fail++;
        $display("FAIL full_hold[%0d]: got rdy=%b iv=%b busy=%b expected 00 0 1",
                 c, bus.req_ready, bus.ln_in_valid, bus.busy);
      end
    end
    return_row(1'b0, 2000);
    run_row(0);
    return_row(1'b1, 3000);
    run_row(1);
    bus.req_valid = 2'b00;
    return_row(1'b0, 4000);
    return_row(1'b1, 5000);
    tick();
    n_tests++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rr_idle_after: got busy=%b expected 0", bus.busy);
    end
  endtask

  task automatic test_underrun();
    logic [1:0] exp_rdy;
    do_reset();
    bus.req_valid   = 2'b10;
    bus.req_qin[1]  = DW'(1);
    bus.req_bias[1] = DW'(50);
    tick();
    n_tests++;
    if (bus.req_ready !== 2'b10 || bus.err_underrun !== 1'b0) begin
      n_fail++;
      $display("FAIL under_grant: got rdy=%b eu=%b expected 10 0", bus.req_ready, bus.err_underrun);
    end
    for (int k = 1; k <= 8; k++) begin
      bus.req_valid = (k == 5) ? 2'b00 : 2'b10;
      exp_rdy       = (k == 5) ? 2'b00 : 2'b10;
      #1;
      n_tests++;
      if (bus.req_ready !== exp_rdy) begin
        n_fail++;
        $display("FAIL under_ready[%0d]: got %b expected %b", k, bus.req_ready, exp_rdy);
      end
      tick();
      n_tests++;
      if (bus.ln_in_valid !== 1'b1 || bus.ln_qin !== DW'((k == 5) ? 0 : k) ||
          bus.err_underrun !== (k >= 5)) begin
        n_fail++;
        $display("FAIL under_elem[%0d]: got iv=%b qin=%0d eu=%b expected iv=1 qin=%0d eu=%b",
                 k, bus.ln_in_valid, bus.ln_qin, bus.err_underrun, (k == 5) ? 0 : k, (k >= 5));
      end
      bus.req_qin[1] = DW'(k + 1);
    end
    bus.req_valid = 2'b00;
    for (int g = 0; g < 4; g++) tick();
    n_tests++;
    if (bus.err_underrun !== 1'b1 || bus.ln_in_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL under_sticky: got eu=%b iv=%b expected 1 0", bus.err_underrun, bus.ln_in_valid);
    end
    return_row(1'b1, 6000);
  endtask

  task automatic test_orphan();
    n_tests++;
    if (bus.err_orphan !== 1'b0) begin
      n_fail++;
      $display("FAIL orphan_pre: got %b expected 0", bus.err_orphan);
    end
    bus.ln_out_valid = 1'b1;
    bus.ln_qout      = DW'(77);
    tick();
    bus.ln_out_valid = 1'b0;
    n_tests++;
    if (bus.rsp_valid !== 1'b0 || bus.err_orphan !== 1'b1) begin
      n_fail++;
      $display("FAIL orphan_pulse: got rv=%b eo=%b expected 0 1", bus.rsp_valid, bus.err_orphan);
    end
    tick();
    n_tests++;
    if (bus.err_orphan !== 1'b1 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL orphan_sticky: got eo=%b busy=%b expected 1 0", bus.err_orphan, bus.busy);
    end
  endtask

  task automatic test_reset_mid_row();
    bus.req_valid    = 2'b01;
    bus.req_qin[0]   = DW'(1);
    bus.req_bias[0]  = DW'(9);
    bus.req_shift[0] = 5'd5;
    tick();
    for (int k = 1; k <= 2; k++) begin
      tick();
      bus.req_qin[0] = DW'(k + 1);
    end
    rst = 1'b1;
    tick();
    n_tests++;
    if (bus.ln_enable !== 1'b0 || bus.ln_in_valid !== 1'b0 || bus.ln_qin !== DW'(0) ||
        bus.ln_bias !== DW'(0) || bus.ln_shift !== 5'd0 || bus.req_ready !== 2'b00 ||
        bus.busy !== 1'b0 || bus.rsp_valid !== 1'b0 ||
        bus.err_underrun !== 1'b0 || bus.err_orphan !== 1'b0) begin
      n_fail++;
      $display("FAIL midrow_reset: got en=%b iv=%b qin=%0d bias=%0d sh=%0d rdy=%b busy=%b rv=%b eu=%b eo=%b expected all 0",
               bus.ln_enable, bus.ln_in_valid, bus.ln_qin, bus.ln_bias, bus.ln_shift,
               bus.req_ready, bus.busy, bus.rsp_valid, bus.err_underrun, bus.err_orphan);
    end
    rst = 1'b0;
    bus.req_qin[0] = DW'(11);
    tick();
    n_tests++;
    if (bus.req_ready !== 2'b01 || bus.ln_shift !== 5'd5) begin
      n_fail++;
      $display("FAIL midrow_regrant: got rdy=%b sh=%0d expected 01 5", bus.req_ready, bus.ln_shift);
    end
    tick();
    n_tests++;
    if (bus.ln_in_valid !== 1'b1 || bus.ln_qin !== DW'(11)) begin
      n_fail++;
      $display("FAIL midrow_first_elem: got iv=%b qin=%0d expected 1 11", bus.ln_in_valid, bus.ln_qin);
    end
    bus.req_valid = 2'b00;
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single_row();
    test_round_robin();
    test_underrun();
    test_orphan();
    test_reset_mid_row();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/layer_norm_sched.md
LAYER_NORM_SCHED -- requirements
Module: layer_norm_sched

Interface
REQ-001 Parameter: D_W_ACC, default 32, width of element, bias and result words.
REQ-002 Parameter: N, default 768, elements per row (vector length of the layer-norm datapath).
REQ-003 Parameter: NUM_REQ, default 2, number of requesters sharing the datapath.
REQ-004 Parameter: MAX_OUT, default 4, maximum rows in flight (tag FIFO depth, power of 2).
REQ-005 Parameter: ROW_GAP, default 64, idle cycles forced after each row before the next grant.
REQ-006 Clock and reset: one clock; reset is synchronous and active-high.
REQ-007 clk  in  1  clock, all logic on rising edge.
REQ-008 rst  in  1  synchronous active-high reset.
REQ-009 req_valid  in  [NUM_REQ]  requester i has an element on its data/bias lanes.
REQ-010 req_ready  out  [NUM_REQ]  element from requester i accepted this cycle.
REQ-011 req_qin  in  [NUM_REQ][D_W_ACC]  signed element per requester.
REQ-012 req_bias  in  [NUM_REQ][D_W_ACC]  signed bias per requester.
REQ-013 req_shift  in  [NUM_REQ][$clog2(D_W_ACC)]  scaling shift per requester, sampled at grant.
REQ-014 ln_enable, ln_in_valid  out  1 each  datapath enable and element strobe.
REQ-015 ln_qin, ln_bias  out  D_W_ACC each; ln_shift  out  $clog2(D_W_ACC)  datapath operands.
REQ-016 ln_out_valid  in  1; ln_qout  in  D_W_ACC  datapath result stream.
REQ-017 rsp_valid  out  1; rsp_id  out  $clog2(NUM_REQ); rsp_data  out  D_W_ACC; rsp_last  out  1  routed results, no backpressure.
REQ-018 busy  out  1  state != IDLE or rows in flight; err_underrun, err_orphan  out  1 each  sticky errors.

Function
REQ-019 FSM states IDLE, STREAM, GAP; reset state IDLE.
REQ-020 IDLE: if any req_valid and tag FIFO not full, grant round-robin winner (search starts at last_grant+1 mod NUM_REQ), latch its id and req_shift, push id into tag FIFO, go STREAM next cycle.
REQ-021 IDLE with tag FIFO full: no grant, remain IDLE.
REQ-022 STREAM: req_ready[g]=req_valid[g] for granted g only, all other req_ready 0; element counter increments every STREAM cycle regardless of req_valid.
REQ-023 STREAM: ln_in_valid=1 every cycle; ln_qin/ln_bias registered copies of granted lanes (1-cycle latency from acceptance); if req_valid[g]=0, drive 0/0 and set err_underrun.
REQ-024 STREAM exits after exactly N cycles: to GAP if ROW_GAP>0, else IDLE; rows are never split or interleaved.
REQ-025 GAP: ln_in_valid=0, counts ROW_GAP cycles then IDLE.
REQ-026 ln_enable=1 whenever not in reset; ln_shift holds latched shift from grant until next grant.
REQ-027 Output path: rsp_valid/rsp_data registered from ln_out_valid/ln_qout (1-cycle latency); rsp_id = tag FIFO head.
REQ-028 Output counter counts ln_out_valid beats 0..N-1; rsp_last=1 on beat N-1, which pops tag FIFO and wraps counter to 0.
REQ-029 ln_out_valid with tag FIFO empty: rsp_valid stays 0, set err_orphan.
REQ-030 Push (grant) and pop (last beat) in same cycle: occupancy unchanged; full check uses pre-pop occupancy.
REQ-031 busy = (state!=IDLE) or tag FIFO non-empty.

Reset
REQ-032 rst, including mid-row: state IDLE, counters 0, last_grant=NUM_REQ-1, tag FIFO empty, all outputs 0, sticky errors cleared; partial row discarded (datapath shares rst).

Structure
REQ-033 Package layer_norm_pkg holds D_W_ACC, N defaults and the state enum type.
REQ-034 Tag FIFO is one sub-module sync_fifo (width $clog2(NUM_REQ), depth MAX_OUT, push/pop/full/empty).

Verification (N=8, ROW_GAP=4, NUM_REQ=2, MAX_OUT=2 bench variant)
REQ-035 Req0 alone valid with qin 1..8 -> grant cycle 1, ln_qin 1..8 on 8 consecutive cycles, ln_in_valid low 4 GAP cycles.
REQ-036 Both requesters continuously valid -> grants alternate 0,1,0,1; rsp_id sequence matches grant order, rsp_last every 8th beat.
REQ-037 Req1 drops valid on element 5 -> ln_qin=0 that cycle, row still 8 beats, err_underrun=1 and stays 1.
REQ-038 Two rows granted, no outputs returned -> third request held (req_ready 0, IDLE); one rsp_last pops, next grant same cycle-plus-one.
REQ-039 ln_out_valid pulse with empty FIFO -> rsp_valid 0, err_orphan=1.
REQ-040 rst asserted at element 3 of a row -> next cycle all outputs 0, busy 0, errors 0; new row starts at element 0.
